// File: rtl/payload_generator_top.sv
// Order-payload framer: captures per-PE order requests, picks the lowest pending PE,
// and streams a 60-byte big-endian payload (59 data bytes + checksum) as two 256-bit AXIS beats.

module payload_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] req,
    output logic         pending,
    output logic [W-1:0] fields
);
    // A new strobe wins over a same-cycle completion so the fresh request is not lost.
    always_ff @(posedge clk) begin
        if (resetn)   pending <= 1'b0;
        else if (en)  pending <= 1'b1;
        else if (clr) pending <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (en) fields <= req;
    end
endmodule

module payload_generator_top #(
    parameter int NUM_PE = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          tready,
    input  logic [15:0]   session_id,
    input  logic [31:0]   MsgSeqNum,
    input  logic [31:0]   epoch_s,
    input  logic [15:0]   ms,
    input  logic [15:0]   cm_id,
    input  logic [31:0]   investor_acno,
    input  logic [7:0]    investor_flag,
    input  logic [7:0]    order_source,
    input  logic          PE_enable_0,
    input  logic [7:0]    ExecType_0, user_define0_0, user_define1_0, user_define2_0, user_define3_0,
    input  logic [7:0]    user_define4_0, user_define5_0, user_define6_0, user_define7_0,
    input  logic [7:0]    symbol_type_0, side_0, OrdType_0, TimeInForce_0,
    input  logic [159:0]  sym_0,
    input  logic [31:0]   price_0,
    input  logic [15:0]   qty_0,
    input  logic          PE_enable_1,
    input  logic [7:0]    ExecType_1, user_define0_1, user_define1_1, user_define2_1, user_define3_1,
    input  logic [7:0]    user_define4_1, user_define5_1, user_define6_1, user_define7_1,
    input  logic [7:0]    symbol_type_1, side_1, OrdType_1, TimeInForce_1,
    input  logic [159:0]  sym_1,
    input  logic [31:0]   price_1,
    input  logic [15:0]   qty_1,
    input  logic          PE_enable_2,
    input  logic [7:0]    ExecType_2, user_define0_2, user_define1_2, user_define2_2, user_define3_2,
    input  logic [7:0]    user_define4_2, user_define5_2, user_define6_2, user_define7_2,
    input  logic [7:0]    symbol_type_2, side_2, OrdType_2, TimeInForce_2,
    input  logic [159:0]  sym_2,
    input  logic [31:0]   price_2,
    input  logic [15:0]   qty_2,
    input  logic          PE_enable_3,
    input  logic [7:0]    ExecType_3, user_define0_3, user_define1_3, user_define2_3, user_define3_3,
    input  logic [7:0]    user_define4_3, user_define5_3, user_define6_3, user_define7_3,
    input  logic [7:0]    symbol_type_3, side_3, OrdType_3, TimeInForce_3,
    input  logic [159:0]  sym_3,
    input  logic [31:0]   price_3,
    input  logic [15:0]   qty_3,
    input  logic          PE_enable_4,
    input  logic [7:0]    ExecType_4, user_define0_4, user_define1_4, user_define2_4, user_define3_4,
    input  logic [7:0]    user_define4_4, user_define5_4, user_define6_4, user_define7_4,
    input  logic [7:0]    symbol_type_4, side_4, OrdType_4, TimeInForce_4,
    input  logic [159:0]  sym_4,
    input  logic [31:0]   price_4,
    input  logic [15:0]   qty_4,
    input  logic          PE_enable_5,
    input  logic [7:0]    ExecType_5, user_define0_5, user_define1_5, user_define2_5, user_define3_5,
    input  logic [7:0]    user_define4_5, user_define5_5, user_define6_5, user_define7_5,
    input  logic [7:0]    symbol_type_5, side_5, OrdType_5, TimeInForce_5,
    input  logic [159:0]  sym_5,
    input  logic [31:0]   price_5,
    input  logic [15:0]   qty_5,
    input  logic          PE_enable_6,
    input  logic [7:0]    ExecType_6, user_define0_6, user_define1_6, user_define2_6, user_define3_6,
    input  logic [7:0]    user_define4_6, user_define5_6, user_define6_6, user_define7_6,
    input  logic [7:0]    symbol_type_6, side_6, OrdType_6, TimeInForce_6,
    input  logic [159:0]  sym_6,
    input  logic [31:0]   price_6,
    input  logic [15:0]   qty_6,
    input  logic          PE_enable_7,
    input  logic [7:0]    ExecType_7, user_define0_7, user_define1_7, user_define2_7, user_define3_7,
    input  logic [7:0]    user_define4_7, user_define5_7, user_define6_7, user_define7_7,
    input  logic [7:0]    symbol_type_7, side_7, OrdType_7, TimeInForce_7,
    input  logic [159:0]  sym_7,
    input  logic [31:0]   price_7,
    input  logic [15:0]   qty_7,
    input  logic          PE_enable_8,
    input  logic [7:0]    ExecType_8, user_define0_8, user_define1_8, user_define2_8, user_define3_8,
    input  logic [7:0]    user_define4_8, user_define5_8, user_define6_8, user_define7_8,
    input  logic [7:0]    symbol_type_8, side_8, OrdType_8, TimeInForce_8,
    input  logic [159:0]  sym_8,
    input  logic [31:0]   price_8,
    input  logic [15:0]   qty_8,
    input  logic          PE_enable_9,
    input  logic [7:0]    ExecType_9, user_define0_9, user_define1_9, user_define2_9, user_define3_9,
    input  logic [7:0]    user_define4_9, user_define5_9, user_define6_9, user_define7_9,
    input  logic [7:0]    symbol_type_9, side_9, OrdType_9, TimeInForce_9,
    input  logic [159:0]  sym_9,
    input  logic [31:0]   price_9,
    input  logic [15:0]   qty_9,
    output logic [NUM_PE-1:0] PE_acks,
    output logic          tvalid,
    output logic          tlast,
    output logic [255:0]  data,
    output logic [31:0]   tkeep,
    output logic [31:0]   tstrb
);
    localparam int MAX_PE = 10;

    // Field order matches wire order, so the packed struct is the tail of the byte stream.
    typedef struct packed {
        logic [7:0]   exec_type;
        logic [63:0]  user_define;   // user_define0 in the top byte
        logic [7:0]   symbol_type;
        logic [159:0] sym;
        logic [31:0]  price;
        logic [15:0]  qty;
        logic [7:0]   side;
        logic [7:0]   ord_type;
        logic [7:0]   tif;
    } order_req_t;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    order_req_t [MAX_PE-1:0] req_in;
    order_req_t [MAX_PE-1:0] slot_q;
    logic [MAX_PE-1:0]       en_in, pending, clr;

    assign en_in = {PE_enable_9, PE_enable_8, PE_enable_7, PE_enable_6, PE_enable_5,
                    PE_enable_4, PE_enable_3, PE_enable_2, PE_enable_1, PE_enable_0};

    assign req_in[0] = {ExecType_0, user_define0_0, user_define1_0, user_define2_0, user_define3_0,
                        user_define4_0, user_define5_0, user_define6_0, user_define7_0,
                        symbol_type_0, sym_0, price_0, qty_0, side_0, OrdType_0, TimeInForce_0};
    assign req_in[1] = {ExecType_1, user_define0_1, user_define1_1, user_define2_1, user_define3_1,
                        user_define4_1, user_define5_1, user_define6_1, user_define7_1,
                        symbol_type_1, sym_1, price_1, qty_1, side_1, OrdType_1, TimeInForce_1};
    assign req_in[2] = {ExecType_2, user_define0_2, user_define1_2, user_define2_2, user_define3_2,
                        user_define4_2, user_define5_2, user_define6_2, user_define7_2,
                        symbol_type_2, sym_2, price_2, qty_2, side_2, OrdType_2, TimeInForce_2};
    assign req_in[3] = {ExecType_3, user_define0_3, user_define1_3, user_define2_3, user_define3_3,
                        user_define4_3, user_define5_3, user_define6_3, user_define7_3,
                        symbol_type_3, sym_3, price_3, qty_3, side_3, OrdType_3, TimeInForce_3};
    assign req_in[4] = {ExecType_4, user_define0_4, user_define1_4, user_define2_4, user_define3_4,
                        user_define4_4, user_define5_4, user_define6_4, user_define7_4,
                        symbol_type_4, sym_4, price_4, qty_4, side_4, OrdType_4, TimeInForce_4};
    assign req_in[5] = {ExecType_5, user_define0_5, user_define1_5, user_define2_5, user_define3_5,
                        user_define4_5, user_define5_5, user_define6_5, user_define7_5,
                        symbol_type_5, sym_5, price_5, qty_5, side_5, OrdType_5, TimeInForce_5};
    assign req_in[6] = {ExecType_6, user_define0_6, user_define1_6, user_define2_6, user_define3_6,
                        user_define4_6, user_define5_6, user_define6_6, user_define7_6,
                        symbol_type_6, sym_6, price_6, qty_6, side_6, OrdType_6, TimeInForce_6};
    assign req_in[7] = {ExecType_7, user_define0_7, user_define1_7, user_define2_7, user_define3_7,
                        user_define4_7, user_define5_7, user_define6_7, user_define7_7,
                        symbol_type_7, sym_7, price_7, qty_7, side_7, OrdType_7, TimeInForce_7};
    assign req_in[8] = {ExecType_8, user_define0_8, user_define1_8, user_define2_8, user_define3_8,
                        user_define4_8, user_define5_8, user_define6_8, user_define7_8,
                        symbol_type_8, sym_8, price_8, qty_8, side_8, OrdType_8, TimeInForce_8};
    assign req_in[9] = {ExecType_9, user_define0_9, user_define1_9, user_define2_9, user_define3_9,
                        user_define4_9, user_define5_9, user_define6_9, user_define7_9,
                        symbol_type_9, sym_9, price_9, qty_9, side_9, OrdType_9, TimeInForce_9};

    for (genvar i = 0; i < MAX_PE; i++) begin : g_slot
        if (i < NUM_PE) begin : g_used
            payload_slot #(.W($bits(order_req_t))) u_slot (
                .clk     (clk),
                .resetn  (resetn),
                .en      (en_in[i]),
                .clr     (clr[i]),
                .req     (req_in[i]),
                .pending (pending[i]),
                .fields  (slot_q[i])
            );
        end else begin : g_unused
            assign pending[i] = 1'b0;
            assign slot_q[i]  = '0;
        end
    end

    state_t                 state_q, state_d;
    logic [3:0]             win_idx, win_q, win_d;
    logic [471:0]           stream;
    logic [59:0][7:0]       frame_bytes;
    logic [7:0]             csum;
    logic [27:0][7:0]       tail_q, tail_d;
    logic                   tvalid_d, tlast_d;
    logic [255:0]           data_d;
    logic [31:0]            tkeep_d;
    logic [NUM_PE-1:0]      ack_d;

    always_comb begin
        win_idx = '0;
        for (int i = MAX_PE - 1; i >= 0; i--)
            if (pending[i]) win_idx = 4'(i);
    end

    // Payload built straight from live common inputs and the winning slot at launch.
    always_comb begin
        stream = {session_id, MsgSeqNum, epoch_s, ms, cm_id, investor_acno,
                  investor_flag, order_source, slot_q[win_idx]};
        csum   = '0;
        frame_bytes = '0;
        for (int k = 0; k < 59; k++) begin
            frame_bytes[k] = stream[8*(58-k) +: 8];
            csum           = csum + frame_bytes[k];
        end
        frame_bytes[59] = csum;
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        tail_d   = tail_q;
        tvalid_d = tvalid;
        tlast_d  = tlast;
        data_d   = data;
        tkeep_d  = tkeep;
        ack_d    = '0;
        clr      = '0;
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    state_d  = BEAT0;
                    win_d    = win_idx;
                    tail_d   = frame_bytes[59:32];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    data_d   = frame_bytes[31:0];
                    tkeep_d  = 32'hFFFF_FFFF;
                end
            end
            BEAT0: begin
                if (tready) begin
                    state_d = BEAT1;
                    tlast_d = 1'b1;
                    data_d  = {32'd0, tail_q};
                    tkeep_d = 32'h0FFF_FFFF;
                end
            end
            BEAT1: begin
                if (tready) begin
                    state_d  = IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    data_d   = '0;
                    tkeep_d  = '0;
                    for (int i = 0; i < MAX_PE; i++)
                        if (win_q == 4'(i)) clr[i] = 1'b1;
                    for (int i = 0; i < NUM_PE; i++)
                        if (win_q == 4'(i)) ack_d[i] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= IDLE;
            win_q   <= '0;
            tail_q  <= '0;
            tvalid  <= 1'b0;
            tlast   <= 1'b0;
            data    <= '0;
            tkeep   <= '0;
            PE_acks <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            tail_q  <= tail_d;
            tvalid  <= tvalid_d;
            tlast   <= tlast_d;
            data    <= data_d;
            tkeep   <= tkeep_d;
            PE_acks <= ack_d;
        end
    end

    assign tstrb = tkeep;
endmodule

// File: tb/tb_payload_generator_top.sv
// Randomised bench for payload_generator_top against a byte-list model of the payload.

module tb_payload_generator_top;
    logic clk = 1'b0, resetn, tready;
    logic [15:0] session_id, ms, cm_id;
    logic [31:0] MsgSeqNum, epoch_s, investor_acno;
    logic [7:0]  investor_flag, order_source;
    logic [9:0]  pe_en;
    logic [7:0]  exec_type [10], symbol_type [10], side [10], ord_type [10], tif [10];
    logic [7:0]  ud [10][8];
    logic [159:0] sym [10];
    logic [31:0] price [10];
    logic [15:0] qty [10];
    logic [9:0]  PE_acks;
    logic        tvalid, tlast;
    logic [255:0] data;
    logic [31:0] tkeep, tstrb;

    int nchk = 0, nfail = 0;
    logic [7:0] exp_b [60];
    int wp;

    always #5 clk = ~clk;

    payload_generator_top #(.NUM_PE(10)) dut (
        .clk(clk), .resetn(resetn), .tready(tready),
        .session_id(session_id), .MsgSeqNum(MsgSeqNum), .epoch_s(epoch_s), .ms(ms), .cm_id(cm_id),
        .investor_acno(investor_acno), .investor_flag(investor_flag), .order_source(order_source),
        .PE_enable_0(pe_en[0]), .ExecType_0(exec_type[0]), .user_define0_0(ud[0][0]), .user_define1_0(ud[0][1]), .user_define2_0(ud[0][2]), .user_define3_0(ud[0][3]), .user_define4_0(ud[0][4]), .user_define5_0(ud[0][5]), .user_define6_0(ud[0][6]), .user_define7_0(ud[0][7]),
        .symbol_type_0(symbol_type[0]), .side_0(side[0]), .OrdType_0(ord_type[0]), .TimeInForce_0(tif[0]), .sym_0(sym[0]), .price_0(price[0]), .qty_0(qty[0]),
        .PE_enable_1(pe_en[1]), .ExecType_1(exec_type[1]), .user_define0_1(ud[1][0]), .user_define1_1(ud[1][1]), .user_define2_1(ud[1][2]), .user_define3_1(ud[1][3]), .user_define4_1(ud[1][4]), .user_define5_1(ud[1][5]), .user_define6_1(ud[1][6]), .user_define7_1(ud[1][7]),
        .symbol_type_1(symbol_type[1]), .side_1(side[1]), .OrdType_1(ord_type[1]), .TimeInForce_1(tif[1]), .sym_1(sym[1]), .price_1(price[1]), .qty_1(qty[1]),
        .PE_enable_2(pe_en[2]), .ExecType_2(exec_type[2]), .user_define0_2(ud[2][0]), .user_define1_2(ud[2][1]), .user_define2_2(ud[2][2]), .user_define3_2(ud[2][3]), .user_define4_2(ud[2][4]), .user_define5_2(ud[2][5]), .user_define6_2(ud[2][6]), .user_define7_2(ud[2][7]),
        .symbol_type_2(symbol_type[2]), .side_2(side[2]), .OrdType_2(ord_type[2]), .TimeInForce_2(tif[2]), .sym_2(sym[2]), .price_2(price[2]), .qty_2(qty[2]),
        .PE_enable_3(pe_en[3]), .ExecType_3(exec_type[3]), .user_define0_3(ud[3][0]), .user_define1_3(ud[3][1]), .user_define2_3(ud[3][2]), .user_define3_3(ud[3][3]), .user_define4_3(ud[3][4]), .user_define5_3(ud[3][5]), .user_define6_3(ud[3][6]), .user_define7_3(ud[3][7]),
        .symbol_type_3(symbol_type[3]), .side_3(side[3]), .OrdType_3(ord_type[3]), .TimeInForce_3(tif[3]), .sym_3(sym[3]), .price_3(price[3]), .qty_3(qty[3]),
        .PE_enable_4(pe_en[4]), .ExecType_4(exec_type[4]), .user_define0_4(ud[4][0]), .user_define1_4(ud[4][1]), .user_define2_4(ud[4][2]), .user_define3_4(ud[4][3]), .user_define4_4(ud[4][4]), .user_define5_4(ud[4][5]), .user_define6_4(ud[4][6]), .user_define7_4(ud[4][7]),
        .symbol_type_4(symbol_type[4]), .side_4(side[4]), .OrdType_4(ord_type[4]), .TimeInForce_4(tif[4]), .sym_4(sym[4]), .price_4(price[4]), .qty_4(qty[4]),
        .PE_enable_5(pe_en[5]), .ExecType_5(exec_type[5]), .user_define0_5(ud[5][0]), .user_define1_5(ud[5][1]), .user_define2_5(ud[5][2]), .user_define3_5(ud[5][3]), .user_define4_5(ud[5][4]), .user_define5_5(ud[5][5]), .user_define6_5(ud[5][6]), .user_define7_5(ud[5][7]),
        .symbol_type_5(symbol_type[5]), .side_5(side[5]), .OrdType_5(ord_type[5]), .TimeInForce_5(tif[5]), .sym_5(sym[5]), .price_5(price[5]), .qty_5(qty[5]),
        .PE_enable_6(pe_en[6]), .ExecType_6(exec_type[6]), .user_define0_6(ud[6][0]), .user_define1_6(ud[6][1]), .user_define2_6(ud[6][2]), .user_define3_6(ud[6][3]), .user_define4_6(ud[6][4]), .user_define5_6(ud[6][5]), .user_define6_6(ud[6][6]), .user_define7_6(ud[6][7]),
        .symbol_type_6(symbol_type[6]), .side_6(side[6]), .OrdType_6(ord_type[6]), .TimeInForce_6(tif[6]), .sym_6(sym[6]), .price_6(price[6]), .qty_6(qty[6]),
        .PE_enable_7(pe_en[7]), .ExecType_7(exec_type[7]), .user_define0_7(ud[7][0]), .user_define1_7(ud[7][1]), .user_define2_7(ud[7][2]), .user_define3_7(ud[7][3]), .user_define4_7(ud[7][4]), .user_define5_7(ud[7][5]), .user_define6_7(ud[7][6]), .user_define7_7(ud[7][7]),
        .symbol_type_7(symbol_type[7]), .side_7(side[7]), .OrdType_7(ord_type[7]), .TimeInForce_7(tif[7]), .sym_7(sym[7]), .price_7(price[7]), .qty_7(qty[7]),
        .PE_enable_8(pe_en[8]), .ExecType_8(exec_type[8]), .user_define0_8(ud[8][0]), .user_define1_8(ud[8][1]), .user_define2_8(ud[8][2]), .user_define3_8(ud[8][3]), .user_define4_8(ud[8][4]), .user_define5_8(ud[8][5]), .user_define6_8(ud[8][6]), .user_define7_8(ud[8][7]),
        .symbol_type_8(symbol_type[8]), .side_8(side[8]), .OrdType_8(ord_type[8]), .TimeInForce_8(tif[8]), .sym_8(sym[8]), .price_8(price[8]), .qty_8(qty[8]),
        .PE_enable_9(pe_en[9]), .ExecType_9(exec_type[9]), .user_define0_9(ud[9][0]), .user_define1_9(ud[9][1]), .user_define2_9(ud[9][2]), .user_define3_9(ud[9][3]), .user_define4_9(ud[9][4]), .user_define5_9(ud[9][5]), .user_define6_9(ud[9][6]), .user_define7_9(ud[9][7]),
        .symbol_type_9(symbol_type[9]), .side_9(side[9]), .OrdType_9(ord_type[9]), .TimeInForce_9(tif[9]), .sym_9(sym[9]), .price_9(price[9]), .qty_9(qty[9]),
        .PE_acks(PE_acks), .tvalid(tvalid), .tlast(tlast), .data(data), .tkeep(tkeep), .tstrb(tstrb)
    );

    // Model: append each field most-significant byte first, then the mod-256 sum.
    task automatic put(input logic [159:0] v, input int n);
        for (int b = n - 1; b >= 0; b--) begin
            exp_b[wp] = v[8*b +: 8];
            wp++;
        end
    endtask

    task automatic build_exp(input int p);
        int sum;
        wp = 0;
        put(160'(session_id), 2); put(160'(MsgSeqNum), 4); put(160'(epoch_s), 4); put(160'(ms), 2);
        put(160'(cm_id), 2); put(160'(investor_acno), 4); put(160'(investor_flag), 1);
        put(160'(order_source), 1); put(160'(exec_type[p]), 1);
        for (int k = 0; k < 8; k++) put(160'(ud[p][k]), 1);
        put(160'(symbol_type[p]), 1); put(sym[p], 20); put(160'(price[p]), 4); put(160'(qty[p]), 2);
        put(160'(side[p]), 1); put(160'(ord_type[p]), 1); put(160'(tif[p]), 1);
        sum = 0;
        for (int k = 0; k < 59; k++) sum += int'(exp_b[k]);
        exp_b[59] = 8'(sum % 256);
    endtask

    task automatic rand_pe(input int p);
        exec_type[p] = 8'($urandom); symbol_type[p] = 8'($urandom); side[p] = 8'($urandom);
        ord_type[p] = 8'($urandom); tif[p] = 8'($urandom);
        for (int k = 0; k < 8; k++) ud[p][k] = 8'($urandom);
        sym[p] = {$urandom, $urandom, $urandom, $urandom, $urandom};
        price[p] = $urandom; qty[p] = 16'($urandom);
    endtask

    task automatic rand_common();
        session_id = 16'($urandom); MsgSeqNum = $urandom; epoch_s = $urandom; ms = 16'($urandom);
        cm_id = 16'($urandom); investor_acno = $urandom; investor_flag = 8'($urandom);
        order_source = 8'($urandom);
    endtask

    task automatic pulse(input logic [9:0] mask);
        pe_en = mask;
        @(negedge clk);
        pe_en = '0;
    endtask

    // Receives one frame for PE p, checking every presented cycle, then the ack and idle gap.
    task automatic run_frame(input int p, input int stall0, input bit rand_bp, input string tag);
        logic [255:0] e0, e1, ew;
        logic [9:0]   eack;
        int beat, stalls, guard;
        bit tr;
        build_exp(p);
        e0 = '0; e1 = '0;
        for (int k = 0; k < 32; k++) e0[8*k +: 8] = exp_b[k];
        for (int k = 0; k < 28; k++) e1[8*k +: 8] = exp_b[32+k];
        eack = 10'(1) << p;
        guard = 0;
        while (tvalid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        nchk++;
        if (tvalid !== 1'b1) begin
            $display("FAIL %s start: tvalid=%b after %0d cycles, want 1", tag, tvalid, guard);
            nfail++;
            return;
        end
        beat = 0; stalls = 0; guard = 0;
        while (beat < 2 && guard < 60) begin
            ew = (beat == 0) ? e0 : e1;
            nchk++; if (data !== ew) begin $display("FAIL %s data beat%0d: got %h want %h", tag, beat, data, ew); nfail++; end
            nchk++; if (tkeep !== (beat == 0 ? 32'hFFFFFFFF : 32'h0FFFFFFF)) begin $display("FAIL %s tkeep beat%0d: got %h", tag, beat, tkeep); nfail++; end
            nchk++; if (tstrb !== tkeep) begin $display("FAIL %s tstrb beat%0d: got %h want %h", tag, beat, tstrb, tkeep); nfail++; end
            nchk++; if (tlast !== (beat == 1)) begin $display("FAIL %s tlast beat%0d: got %b", tag, beat, tlast); nfail++; end
            nchk++; if (tvalid !== 1'b1) begin $display("FAIL %s tvalid beat%0d: got %b want 1", tag, beat, tvalid); nfail++; end
            nchk++; if (PE_acks !== 10'd0) begin $display("FAIL %s early ack: got %b want 0", tag, PE_acks); nfail++; end
            if (beat == 1) begin
                nchk++; if (data[255:224] !== 32'd0) begin $display("FAIL %s pad lanes: got %h want 0", tag, data[255:224]); nfail++; end
                nchk++; if (data[223:216] !== exp_b[59]) begin $display("FAIL %s checksum: got %h want %h", tag, data[223:216], exp_b[59]); nfail++; end
            end
            if (beat == 0 && stalls < stall0) begin tr = 1'b0; stalls++; end
            else tr = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tready = tr;
            @(negedge clk);
            if (tr) beat++;
            guard++;
        end
        nchk++;
        if (beat != 2) begin $display("FAIL %s beats: got %0d want 2", tag, beat); nfail++; end
        tready = 1'b1;
        nchk++; if (PE_acks !== eack) begin $display("FAIL %s ack: got %b want %b", tag, PE_acks, eack); nfail++; end
        nchk++; if (tvalid !== 1'b0 || tkeep !== 32'd0 || data !== 256'd0) begin
            $display("FAIL %s idle gap: tvalid=%b tkeep=%h want 0", tag, tvalid, tkeep); nfail++; end
        @(negedge clk);
        nchk++; if (PE_acks !== 10'd0) begin $display("FAIL %s ack width: got %b want 0", tag, PE_acks); nfail++; end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        nchk++; if (tvalid !== 1'b0) begin $display("FAIL reset tvalid: got %b want 0", tvalid); nfail++; end
        nchk++; if (tkeep !== 32'd0 || tstrb !== 32'd0) begin $display("FAIL reset tkeep: got %h/%h want 0", tkeep, tstrb); nfail++; end
        nchk++; if (PE_acks !== 10'd0) begin $display("FAIL reset acks: got %b want 0", PE_acks); nfail++; end
        nchk++; if (tlast !== 1'b0 || data !== 256'd0) begin $display("FAIL reset data: tlast=%b data=%h want 0", tlast, data); nfail++; end
        repeat (3) begin
            @(negedge clk);
            nchk++; if (tvalid !== 1'b0) begin $display("FAIL reset idle tvalid: got %b want 0", tvalid); nfail++; end
        end
    endtask

    task automatic test_single();
        rand_common();
        session_id = 16'h00df; MsgSeqNum = 32'h0000_0b23; epoch_s = 32'h5e4c_9098; ms = 16'h0096;
        rand_pe(1);
        pulse(10'b10);
        nchk++; if (tvalid !== 1'b0) begin $display("FAIL single latency early: tvalid=%b want 0", tvalid); nfail++; end
        @(negedge clk);
        nchk++; if (tvalid !== 1'b1) begin $display("FAIL single latency: tvalid=%b want 1", tvalid); nfail++; end
        nchk++; if (data[15:0] !== 16'hdf00) begin $display("FAIL single session bytes: got %h want df00", data[15:0]); nfail++; end
        run_frame(1, 0, 1'b0, "single");
    endtask

    task automatic test_priority();
        rand_pe(0); rand_pe(2);
        pulse(10'b101);
        run_frame(0, 0, 1'b0, "prio_pe0");
        run_frame(2, 0, 1'b0, "prio_pe2");
    endtask

    task automatic test_backpressure();
        rand_common(); rand_pe(6);
        pulse(10'b0001000000);
        run_frame(6, 3, 1'b0, "backpressure");
    endtask

    task automatic test_overwrite();
        rand_pe(0);
        tready = 1'b0;
        pulse(10'b1);
        @(negedge clk);
        rand_pe(7);
        pulse(10'b0010000000);
        rand_pe(7);
        pulse(10'b0010000000);
        run_frame(0, 0, 1'b0, "overwrite_pe0");
        run_frame(7, 0, 1'b0, "overwrite_pe7");
    endtask

    task automatic test_checksum();
        int p;
        for (int it = 0; it < 8; it++) begin
            p = $urandom_range(0, 9);
            rand_common(); rand_pe(p);
            pulse(10'(1) << p);
            run_frame(p, 0, 1'b1, "random");
        end
    endtask

    task automatic test_reset_mid();
        rand_pe(3);
        tready = 1'b1;
        pulse(10'b1000);
        @(negedge clk);
        @(negedge clk);
        nchk++; if (tlast !== 1'b1) begin $display("FAIL midreset in beat1: tlast=%b want 1", tlast); nfail++; end
        tready = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        tready = 1'b1;
        nchk++; if (tvalid !== 1'b0 || tkeep !== 32'd0 || tlast !== 1'b0 || data !== 256'd0) begin
            $display("FAIL midreset outputs: tvalid=%b tkeep=%h tlast=%b", tvalid, tkeep, tlast); nfail++; end
        nchk++; if (PE_acks !== 10'd0) begin $display("FAIL midreset ack: got %b want 0", PE_acks); nfail++; end
        repeat (4) begin
            @(negedge clk);
            nchk++; if (tvalid !== 1'b0 || PE_acks !== 10'd0) begin
                $display("FAIL midreset pending: tvalid=%b acks=%b want 0", tvalid, PE_acks); nfail++; end
        end
        rand_pe(4);
        pulse(10'b10000);
        run_frame(4, 0, 1'b0, "after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1; tready = 1'b1; pe_en = '0;
        rand_common();
        for (int p = 0; p < 10; p++) rand_pe(p);
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_overwrite();
        test_checksum();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
